// File: rtl/ddr_info_pkg.sv
// ----------------------------------------------------------------------------
// ddr_info_pkg
// Shared constants and types for the DDR info write-side packer.
//   DDR_INFO_IN_W / DDR_INFO_OUT_W / DDR_INFO_RATIO : default word, beat widths
//   ddr_info_state_e : packer FSM state
//   ddr_info_lane_t  : lane index for the default ratio
// ----------------------------------------------------------------------------
package ddr_info_pkg;

   localparam int DDR_INFO_IN_W  = 32;
   localparam int DDR_INFO_OUT_W = 256;
   localparam int DDR_INFO_RATIO = DDR_INFO_OUT_W / DDR_INFO_IN_W;

   typedef enum logic [1:0] {
      FILL,
      PAD,
      FLUSH_WAIT,
      FLUSH_DONE
   } ddr_info_state_e;

   typedef logic [$clog2(DDR_INFO_RATIO)-1:0] ddr_info_lane_t;

endpackage

// File: rtl/ddr_info_packer_if.sv
// ----------------------------------------------------------------------------
// ddr_info_packer_if
// Groups the producer word stream and the 256-bit FIFO write port.
//   s_data/s_valid/s_ready      : producer -> packer word handshake
//   o_din/o_wr_en/i_full/i_prog_full : packer -> FIFO write port
// Modports: slave = packer side, master = producer/FIFO (environment) side.
// ----------------------------------------------------------------------------
interface ddr_info_packer_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 256
) ();

   logic [IN_W-1:0]  s_data;
   logic             s_valid;
   logic             s_ready;
   logic [OUT_W-1:0] o_din;
   logic             o_wr_en;
   logic             i_full;
   logic             i_prog_full;

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready,
      output o_din,
      output o_wr_en,
      input  i_full,
      input  i_prog_full
   );

   modport master (
      output s_data,
      output s_valid,
      input  s_ready,
      input  o_din,
      input  o_wr_en,
      output i_full,
      output i_prog_full
   );

endinterface

// File: rtl/ddr_info_lane_stage.sv
// ----------------------------------------------------------------------------
// ddr_info_lane_stage
// Staging register for one output beat. Lane k occupies
// [OUT_W-1-k*IN_W -: IN_W], so the first word of a beat lands in the MSBs.
//   clk, rst_n   : clock, async active-low reset
//   i_wr, i_lane, i_data : write i_data into lane i_lane
//   i_clr        : clear the whole staging register
//   o_stage_next : staging contents including this cycle's lane write
//   o_padded     : staging with lanes >= i_lane replaced by PAD_VALUE
// ----------------------------------------------------------------------------
module ddr_info_lane_stage #(
   parameter int               IN_W      = 32,
   parameter int               OUT_W     = 256,
   parameter int               LANE_W    = 3,
   parameter logic [IN_W-1:0]  PAD_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr,
   input  logic              i_clr,
   input  logic [LANE_W-1:0] i_lane,
   input  logic [IN_W-1:0]   i_data,
   output logic [OUT_W-1:0]  o_stage_next,
   output logic [OUT_W-1:0]  o_padded
);

   localparam int R = OUT_W / IN_W;

   logic [OUT_W-1:0] r_stage;

   always_comb begin
      o_stage_next = r_stage;
      o_padded     = r_stage;
      for (int k = 0; k < R; k++) begin
         if (i_wr && (i_lane == LANE_W'(k))) begin
            o_stage_next[OUT_W-1-k*IN_W -: IN_W] = i_data;
         end
         if (LANE_W'(k) >= i_lane) begin
            o_padded[OUT_W-1-k*IN_W -: IN_W] = PAD_VALUE;
         end
      end
   end

   // Lanes above the fill point are never read, so a completed beat needs no clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else if (i_clr) begin
         r_stage <= '0;
      end else if (i_wr) begin
         r_stage <= o_stage_next;
      end
   end

endmodule

// File: rtl/ddr_info_packer.sv
// ----------------------------------------------------------------------------
// ddr_info_packer
// Packs 32-bit info words into 256-bit beats (first word in the MSBs) and
// writes them into a wide FIFO toward DDR. A flush pads and emits a partial
// beat, then pulses flush_done.
//   clk, rst_n  : clock, async active-low reset
//   bus (slave) : word stream in, FIFO write port out
//   flush       : one-cycle request to emit the partial beat
//   flush_done  : one-cycle completion pulse
//   busy        : data staged, beat pending, or flush in progress
// Optional: DDR_INFO_PACKER_STATS_EN adds beat_cnt and pad_cnt outputs.
// OUT_W/IN_W must be a power of two.
// ----------------------------------------------------------------------------
module ddr_info_packer
   import ddr_info_pkg::*;
#(
   parameter int              IN_W      = DDR_INFO_IN_W,
   parameter int              OUT_W     = DDR_INFO_OUT_W,
   parameter logic [IN_W-1:0] PAD_VALUE = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   ddr_info_packer_if.slave    bus,
   input  logic                flush,
   output logic                flush_done,
   output logic                busy
`ifdef DDR_INFO_PACKER_STATS_EN
   ,
   output logic [31:0]         beat_cnt,
   output logic [31:0]         pad_cnt
`endif
);

   localparam int R      = OUT_W / IN_W;
   localparam int LANE_W = (R > 1) ? $clog2(R) : 1;

   ddr_info_state_e   r_state;
   logic [LANE_W-1:0] r_lane;
   logic [OUT_W-1:0]  r_out;
   logic              r_out_pending;
   logic              r_flush_done;
   logic              r_init;        // low in reset, high from the first clk after release

   logic              w_acc;
   logic              w_wr;
   logic              w_last;
   logic              w_pad_load;
   logic [OUT_W-1:0]  w_stage_next;
   logic [OUT_W-1:0]  w_padded;

   assign w_wr   = r_out_pending && !bus.i_full;
   assign w_last = (r_lane == LANE_W'(R - 1));
   assign w_acc  = bus.s_valid && bus.s_ready;
   // Lanes are staged and the output register is (or becomes) free this cycle.
   assign w_pad_load = (r_state == PAD) && (r_lane != '0) && (!r_out_pending || w_wr);

   assign bus.s_ready = r_init && !bus.i_prog_full && (!r_out_pending || !bus.i_full) &&
                        (r_state == FILL);
   assign bus.o_wr_en = w_wr;
   assign bus.o_din   = r_out;
   assign flush_done  = r_flush_done;
   assign busy        = (r_lane != '0) || r_out_pending || (r_state != FILL);

   ddr_info_lane_stage #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .LANE_W    (LANE_W),
      .PAD_VALUE (PAD_VALUE)
   ) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_wr         (w_acc),
      .i_clr        (w_pad_load),
      .i_lane       (r_lane),
      .i_data       (bus.s_data),
      .o_stage_next (w_stage_next),
      .o_padded     (w_padded)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= FILL;
         r_lane        <= '0;
         r_out         <= '0;
         r_out_pending <= 1'b0;
         r_flush_done  <= 1'b0;
         r_init        <= 1'b0;
      end else begin
         r_init       <= 1'b1;
         r_flush_done <= 1'b0;
         if (w_wr) begin
            r_out_pending <= 1'b0;
         end
         // Completing a beat may coincide with writing the previous one.
         if (w_acc) begin
            r_lane <= w_last ? '0 : r_lane + 1'b1;
            if (w_last) begin
               r_out         <= w_stage_next;
               r_out_pending <= 1'b1;
            end
         end
         unique case (r_state)
            FILL: begin
               if (flush) begin
                  if ((r_lane == '0) && !w_acc) begin
                     r_state      <= FLUSH_DONE;
                     r_flush_done <= 1'b1;
                  end else begin
                     r_state <= PAD;
                  end
               end
            end
            PAD: begin
               if (w_pad_load) begin
                  r_out         <= w_padded;
                  r_out_pending <= 1'b1;
                  r_lane        <= '0;
                  r_state       <= FLUSH_WAIT;
               end else if (r_lane == '0) begin
                  // Flush arrived with the beat's last word: nothing to pad, just
                  // wait out the full beat instead of emitting an all-pad beat.
                  if (r_out_pending && !w_wr) begin
                     r_state <= FLUSH_WAIT;
                  end else begin
                     r_state      <= FLUSH_DONE;
                     r_flush_done <= 1'b1;
                  end
               end
            end
            FLUSH_WAIT: begin
               if (w_wr) begin
                  r_state      <= FLUSH_DONE;
                  r_flush_done <= 1'b1;
               end
            end
            FLUSH_DONE: begin
               r_state <= FILL;
            end
            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

`ifdef DDR_INFO_PACKER_STATS_EN
   logic [31:0] r_beat_cnt;
   logic [31:0] r_pad_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt <= '0;
         r_pad_cnt  <= '0;
      end else begin
         if (w_wr) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
         end
         if (w_pad_load) begin
            r_pad_cnt <= r_pad_cnt + 32'(R - int'(r_lane));
         end
      end
   end

   assign beat_cnt = r_beat_cnt;
   assign pad_cnt  = r_pad_cnt;
`endif

endmodule

// File: tb/tb_ddr_info_packer.sv
// ----------------------------------------------------------------------------
// tb_ddr_info_packer
// Directed self-checking bench for ddr_info_packer (default build).
// ----------------------------------------------------------------------------
module tb_ddr_info_packer;
   import ddr_info_pkg::*;

   logic clk;
   logic rst_n;
   logic flush;
   logic flush_done;
   logic busy;

   int vectors;
   int errors;
   logic [DDR_INFO_OUT_W-1:0] wr_q[$];

   ddr_info_packer_if #(.IN_W(DDR_INFO_IN_W), .OUT_W(DDR_INFO_OUT_W)) bus ();

   ddr_info_packer #(
      .IN_W      (DDR_INFO_IN_W),
      .OUT_W     (DDR_INFO_OUT_W),
      .PAD_VALUE (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .flush      (flush),
      .flush_done (flush_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every FIFO write, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.o_wr_en === 1'b1) wr_q.push_back(bus.o_din);
   end

   function automatic logic [255:0] seq8(input logic [31:0] b);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[255-32*k -: 32] = b + 32'(k);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      int n;
      bus.s_data  = d;
      bus.s_valid = 1'b1;
      n = 0;
      while (bus.s_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         vectors++;
         errors++;
         $display("FAIL push_timeout: s_ready=%b required 1", bus.s_ready);
      end
      tick();
      bus.s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      vectors += 5;
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b need 0", bus.s_ready); end
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b need 0", bus.o_wr_en); end
      if (bus.o_din !== 256'd0) begin errors++; $display("FAIL rst_din: got %h need 0", bus.o_din); end
      if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_flush_done: got %b need 0", flush_done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
      tick();
      rst_n = 1'b1;
      tick();
      vectors++;
      if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b need 1", bus.s_ready); end
   endtask

   task automatic test_full_beat();
      wr_q.delete();
      for (int i = 0; i < 7; i++) push(32'(i));
      vectors++;
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL full_early_wr: got %b need 0", bus.o_wr_en); end
      push(32'h0000_0007);
      vectors += 4;
      if (bus.o_wr_en !== 1'b1) begin errors++; $display("FAIL full_wr_en: got %b need 1", bus.o_wr_en); end
      if (bus.o_din !== {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7}) begin
         errors++; $display("FAIL full_din: got %h", bus.o_din);
      end
      if (bus.o_din[255:224] !== 32'h0) begin errors++; $display("FAIL full_msb: got %h need 0", bus.o_din[255:224]); end
      if (bus.o_din[31:0] !== 32'h7) begin errors++; $display("FAIL full_lsb: got %h need 7", bus.o_din[31:0]); end
      tick();
      vectors += 3;
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_once: got %b need 0", bus.o_wr_en); end
      if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b need 0", busy); end
      if (wr_q.size() != 1) begin errors++; $display("FAIL full_wr_count: got %0d need 1", wr_q.size()); end
   endtask

   task automatic test_backpressure();
      wr_q.delete();
      bus.i_full = 1'b1;
      for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
      vectors += 2;
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL bp_wr_held: got %b need 0", bus.o_wr_en); end
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b need 0", bus.s_ready); end
      repeat (3) tick();
      vectors += 2;
      if (bus.o_din !== seq8(32'h100)) begin errors++; $display("FAIL bp_din_stable: got %h", bus.o_din); end
      if (wr_q.size() != 0) begin errors++; $display("FAIL bp_no_write: got %0d need 0", wr_q.size()); end
      bus.i_full = 1'b0;
      #1;
      vectors++;
      if (bus.o_wr_en !== 1'b1) begin errors++; $display("FAIL bp_release_wr: got %b need 1", bus.o_wr_en); end
      for (int i = 8; i < 16; i++) push(32'h100 + 32'(i));
      repeat (2) tick();
      vectors++;
      if (wr_q.size() != 2) begin
         errors++; $display("FAIL bp_wr_count: got %0d need 2", wr_q.size());
      end else begin
         vectors += 2;
         if (wr_q[0] !== seq8(32'h100)) begin errors++; $display("FAIL bp_beat0: got %h", wr_q[0]); end
         if (wr_q[1] !== seq8(32'h108)) begin errors++; $display("FAIL bp_beat1: got %h", wr_q[1]); end
      end
   endtask

   task automatic test_throttle();
      wr_q.delete();
      for (int i = 0; i < 3; i++) push(32'h200 + 32'(i));
      bus.i_prog_full = 1'b1;
      bus.s_data      = 32'h203;
      bus.s_valid     = 1'b1;
      #1;
      vectors++;
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL thr_ready_now: got %b need 0", bus.s_ready); end
      repeat (3) tick();
      vectors += 2;
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL thr_ready_held: got %b need 0", bus.s_ready); end
      if (busy !== 1'b1) begin errors++; $display("FAIL thr_busy: got %b need 1", busy); end
      bus.i_prog_full = 1'b0;
      #1;
      vectors++;
      if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL thr_resume: got %b need 1", bus.s_ready); end
      tick();
      bus.s_valid = 1'b0;
      for (int i = 4; i < 8; i++) push(32'h200 + 32'(i));
      vectors += 2;
      if (bus.o_wr_en !== 1'b1) begin errors++; $display("FAIL thr_wr_en: got %b need 1", bus.o_wr_en); end
      if (bus.o_din !== seq8(32'h200)) begin errors++; $display("FAIL thr_din: got %h", bus.o_din); end
      tick();
   endtask

   task automatic test_partial_flush();
      wr_q.delete();
      push(32'hA0A0_0001);
      push(32'hB0B0_0002);
      push(32'hC0C0_0003);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors += 2;
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL pf_wr_pad: got %b need 0", bus.o_wr_en); end
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL pf_ready_pad: got %b need 0", bus.s_ready); end
      tick();
      vectors += 3;
      if (bus.o_wr_en !== 1'b1) begin errors++; $display("FAIL pf_wr_en: got %b need 1", bus.o_wr_en); end
      if (bus.o_din !== {32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 160'd0}) begin
         errors++; $display("FAIL pf_din: got %h", bus.o_din);
      end
      if (flush_done !== 1'b0) begin errors++; $display("FAIL pf_done_early: got %b need 0", flush_done); end
      tick();
      vectors += 2;
      if (flush_done !== 1'b1) begin errors++; $display("FAIL pf_done: got %b need 1", flush_done); end
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL pf_wr_once: got %b need 0", bus.o_wr_en); end
      tick();
      vectors += 4;
      if (flush_done !== 1'b0) begin errors++; $display("FAIL pf_done_pulse: got %b need 0", flush_done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL pf_idle: got %b need 0", busy); end
      if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL pf_ready_back: got %b need 1", bus.s_ready); end
      if (wr_q.size() != 1) begin errors++; $display("FAIL pf_wr_count: got %0d need 1", wr_q.size()); end
   endtask

   task automatic test_empty_flush();
      wr_q.delete();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors += 2;
      if (flush_done !== 1'b1) begin errors++; $display("FAIL ef_done: got %b need 1", flush_done); end
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL ef_no_wr: got %b need 0", bus.o_wr_en); end
      tick();
      vectors += 2;
      if (flush_done !== 1'b0) begin errors++; $display("FAIL ef_done_pulse: got %b need 0", flush_done); end
      if (wr_q.size() != 0) begin errors++; $display("FAIL ef_wr_count: got %0d need 0", wr_q.size()); end
   endtask

   task automatic test_same_cycle_flush();
      wr_q.delete();
      bus.s_data  = 32'hD00D_0004;
      bus.s_valid = 1'b1;
      flush       = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      flush       = 1'b0;
      tick();
      vectors += 2;
      if (bus.o_wr_en !== 1'b1) begin errors++; $display("FAIL sf_wr_en: got %b need 1", bus.o_wr_en); end
      if (bus.o_din !== {32'hD00D_0004, 224'd0}) begin errors++; $display("FAIL sf_din: got %h", bus.o_din); end
      tick();
      vectors++;
      if (flush_done !== 1'b1) begin errors++; $display("FAIL sf_done: got %b need 1", flush_done); end
      tick();
   endtask

   task automatic test_reset_mid_beat();
      for (int i = 0; i < 5; i++) push(32'h400 + 32'(i));
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_before: got %b need 1", busy); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors += 3;
      if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b need 0", bus.s_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b need 0", busy); end
      if (bus.o_wr_en !== 1'b0) begin errors++; $display("FAIL rm_wr_en: got %b need 0", bus.o_wr_en); end
      wr_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) push(32'h300 + 32'(i));
      repeat (3) tick();
      vectors++;
      if (wr_q.size() != 1) begin
         errors++; $display("FAIL rm_wr_count: got %0d need 1", wr_q.size());
      end else begin
         vectors++;
         if (wr_q[0] !== seq8(32'h300)) begin errors++; $display("FAIL rm_beat: got %h", wr_q[0]); end
      end
   endtask

   initial begin
      vectors         = 0;
      errors          = 0;
      rst_n           = 1'b0;
      flush           = 1'b0;
      bus.s_data      = '0;
      bus.s_valid     = 1'b0;
      bus.i_full      = 1'b0;
      bus.i_prog_full = 1'b0;
      test_reset();
      test_full_beat();
      test_backpressure();
      test_throttle();
      test_partial_flush();
      test_empty_flush();
      test_same_cycle_flush();
      test_reset_mid_beat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
